// File: rtl/monitor_contador_triangular.sv
// Receive-side checker for a 0..MAX..0 bouncing counter stream: locks on, tracks direction,
// flags peaks/valleys, counts periods and reports violations. Optional: MONITOR_TRIANG_STICKY_ERR_EN.
module monitor_contador_triangular #(
  parameter int WIDTH      = 4,
  parameter int LOCK_COUNT = 2,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 amostra_valida,
  input  logic [WIDTH-1:0]     amostra,
  output logic                 travado,
  output logic                 direcao,
  output logic                 pico,
  output logic                 vale,
  output logic                 erro,
`ifdef MONITOR_TRIANG_STICKY_ERR_EN
  output logic                 erro_sticky,
`endif
  output logic [CNT_WIDTH-1:0] ciclos_completos
);

  localparam int ACQ_W = $clog2(LOCK_COUNT + 1);
  localparam logic [WIDTH-1:0]     MAX_VAL  = '1;
  localparam logic [WIDTH-1:0]     ZERO_VAL = '0;
  localparam logic [WIDTH-1:0]     ONE      = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [ACQ_W-1:0]     ACQ_ONE  = {{(ACQ_W-1){1'b0}}, 1'b1};
  localparam logic [ACQ_W-1:0]     ACQ_LOCK = ACQ_W'(LOCK_COUNT);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, ACQ, LOCK_UP, LOCK_DOWN} state_t;

  state_t               state_reg, state_next;
  logic [ACQ_W-1:0]     acq_reg, acq_next;
  logic [WIDTH-1:0]     prev_reg, prev_next;
  logic                 dir_reg, dir_next;
  logic                 travado_reg, travado_next;
  logic                 pico_reg, pico_next;
  logic                 vale_reg, vale_next;
  logic                 erro_reg, erro_next;
  logic [CNT_WIDTH-1:0] ciclos_reg, ciclos_next;

  logic is_inc, is_dec, step_one, cons_up, cons_down, consistent;
  logic [ACQ_W-1:0] acq_inc;

  // Increments and decrements never wrap; a turn is only legal at the extremes.
  assign is_inc     = (prev_reg != MAX_VAL)  && (amostra == prev_reg + ONE);
  assign is_dec     = (prev_reg != ZERO_VAL) && (amostra == prev_reg - ONE);
  assign step_one   = is_inc | is_dec;
  assign cons_up    = is_inc | ((prev_reg == MAX_VAL) & is_dec);
  assign cons_down  = is_dec | ((prev_reg == ZERO_VAL) & is_inc);
  assign consistent = dir_reg ? cons_down : cons_up;
  assign acq_inc    = acq_reg + ACQ_ONE;

  always_comb begin
    state_next   = state_reg;
    acq_next     = acq_reg;
    prev_next    = prev_reg;
    dir_next     = dir_reg;
    travado_next = travado_reg;
    ciclos_next  = ciclos_reg;
    pico_next    = 1'b0;
    vale_next    = 1'b0;
    erro_next    = 1'b0;
    if (amostra_valida) begin
      prev_next = amostra;
      case (state_reg)
        IDLE: begin
          state_next = ACQ;
          acq_next   = '0;
        end
        ACQ: begin
          if (acq_reg == '0) begin
            if (step_one) begin
              dir_next = is_dec;
              acq_next = ACQ_ONE;
            end
          end else if (consistent) begin
            dir_next = is_dec;
            acq_next = acq_inc;
          end else begin
            acq_next = '0;
            if (step_one) dir_next = is_dec;
          end
          if (acq_next >= ACQ_LOCK) begin
            state_next   = dir_next ? LOCK_DOWN : LOCK_UP;
            travado_next = 1'b1;
          end
        end
        default: begin
          if (consistent) begin
            dir_next   = is_dec;
            state_next = is_dec ? LOCK_DOWN : LOCK_UP;
            pico_next  = (amostra == MAX_VAL);
            if (amostra == ZERO_VAL) begin
              vale_next = 1'b1;
              if (ciclos_reg != '1) ciclos_next = ciclos_reg + CNT_ONE;
            end
          end else begin
            erro_next    = 1'b1;
            travado_next = 1'b0;
            state_next   = ACQ;
            acq_next     = '0;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg   <= IDLE;
      acq_reg     <= '0;
      prev_reg    <= '0;
      dir_reg     <= 1'b0;
      travado_reg <= 1'b0;
      pico_reg    <= 1'b0;
      vale_reg    <= 1'b0;
      erro_reg    <= 1'b0;
      ciclos_reg  <= '0;
    end else begin
      state_reg   <= state_next;
      acq_reg     <= acq_next;
      prev_reg    <= prev_next;
      dir_reg     <= dir_next;
      travado_reg <= travado_next;
      pico_reg    <= pico_next;
      vale_reg    <= vale_next;
      erro_reg    <= erro_next;
      ciclos_reg  <= ciclos_next;
    end
  end

`ifdef MONITOR_TRIANG_STICKY_ERR_EN
  logic sticky_reg;
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)         sticky_reg <= 1'b0;
    else if (erro_next) sticky_reg <= 1'b1;
  end
  assign erro_sticky = sticky_reg;
`endif

  assign travado          = travado_reg;
  assign direcao          = dir_reg;
  assign pico             = pico_reg;
  assign vale             = vale_reg;
  assign erro             = erro_reg;
  assign ciclos_completos = ciclos_reg;

endmodule

// File: tb/tb_monitor_contador_triangular.sv
// Randomized self-checking bench for monitor_contador_triangular against a step-rule reference model.
// Also covers the optional erro_sticky output when MONITOR_TRIANG_STICKY_ERR_EN is defined.
module tb_monitor_contador_triangular;
  localparam int WIDTH = 4;
  localparam int LOCK_COUNT = 2;
  localparam int MAXV = 15;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       amostra_valida = 1'b0;
  logic [3:0] amostra = '0;
  logic       travado, direcao, pico, vale, erro;
  logic [7:0] ciclos_completos;
`ifdef MONITOR_TRIANG_STICKY_ERR_EN
  logic       erro_sticky;
`endif

  int total = 0;
  int bad = 0;

  monitor_contador_triangular #(.WIDTH(WIDTH), .LOCK_COUNT(LOCK_COUNT), .CNT_WIDTH(8)) dut (
    .clock(clock), .reset(reset), .amostra_valida(amostra_valida), .amostra(amostra),
    .travado(travado), .direcao(direcao), .pico(pico), .vale(vale), .erro(erro),
`ifdef MONITOR_TRIANG_STICKY_ERR_EN
    .erro_sticky(erro_sticky),
`endif
    .ciclos_completos(ciclos_completos)
  );

  always #5 clock = ~clock;

  // Reference model: 0 = idle, 1 = acquiring, 2 = locked
  int m_mode, m_prev, m_acq, m_cyc;
  bit m_dir, m_lock, m_pico, m_vale, m_erro, m_sticky;

  task automatic model_reset();
    m_mode = 0; m_prev = 0; m_acq = 0; m_cyc = 0;
    m_dir = 0; m_lock = 0; m_pico = 0; m_vale = 0; m_erro = 0; m_sticky = 0;
  endtask

  task automatic model_step(input bit v, input int a);
    int d;
    bit ok;
    m_pico = 0; m_vale = 0; m_erro = 0;
    if (!v) return;
    d = a - m_prev;
    if (m_dir == 0) ok = (d == 1) || (m_prev == MAXV && d == -1);
    else            ok = (d == -1) || (m_prev == 0 && d == 1);
    if (m_mode == 0) begin
      m_mode = 1; m_acq = 0;
    end else if (m_mode == 2) begin
      if (ok) begin
        m_dir = (d < 0);
        m_pico = (a == MAXV);
        if (a == 0) begin
          m_vale = 1;
          if (m_cyc < 255) m_cyc++;
        end
      end else begin
        m_erro = 1; m_sticky = 1; m_lock = 0; m_mode = 1; m_acq = 0;
      end
    end else begin
      if (m_acq == 0) begin
        if (d == 1 || d == -1) begin m_dir = (d < 0); m_acq = 1; end
      end else if (ok) begin
        m_dir = (d < 0); m_acq++;
      end else begin
        m_acq = 0;
        if (d == 1 || d == -1) m_dir = (d < 0);
      end
      if (m_acq >= LOCK_COUNT) begin m_mode = 2; m_lock = 1; end
    end
    m_prev = a;
  endtask

  function automatic logic [13:0] expv();
    logic s;
    s = 1'b0;
`ifdef MONITOR_TRIANG_STICKY_ERR_EN
    s = m_sticky;
`endif
    return {s, m_lock, m_dir, m_pico, m_vale, m_erro, m_cyc[7:0]};
  endfunction

  function automatic logic [13:0] obsv();
    logic s;
    s = 1'b0;
`ifdef MONITOR_TRIANG_STICKY_ERR_EN
    s = erro_sticky;
`endif
    return {s, travado, direcao, pico, vale, erro, ciclos_completos};
  endfunction

  task automatic send(input bit v, input int a);
    @(negedge clock);
    amostra_valida = v;
    amostra = 4'(a);
    @(posedge clock);
    #1;
    model_step(v, a);
  endtask

  task automatic test_reset();
    model_reset();
    #1;
    if (obsv() !== 14'd0) begin bad++; $display("FAIL reset_initial: got %h want 0", obsv()); end
    total++;
    @(negedge clock) reset = 1'b1;
    for (int i = 0; i < 4; i++) send(1, i);
    @(posedge clock);
    #3 reset = 1'b0;
    #1;
    model_reset();
    if (obsv() !== 14'd0) begin bad++; $display("FAIL reset_async: got %h want 0", obsv()); end
    total++;
    @(negedge clock) reset = 1'b1;
    send(1, 5);
    if (obsv() !== expv() || travado !== 1'b0) begin
      bad++; $display("FAIL reset_first_sample: got %h want %h", obsv(), expv());
    end
    total++;
    @(negedge clock) reset = 1'b0;
    #1 model_reset();
    @(negedge clock) reset = 1'b1;
  endtask

  task automatic test_lock();
    for (int i = 0; i <= 2; i++) begin
      send(1, i);
      if (obsv() !== expv() || travado !== (i == 2) || vale !== 1'b0) begin
        bad++; $display("FAIL lock sample=%0d: got %h want %h", i, obsv(), expv());
      end
      total++;
    end
  endtask

  task automatic test_peak();
    for (int i = 3; i <= 16; i++) begin
      int a = (i == 16) ? 14 : i;
      send(1, a);
      if (obsv() !== expv() || pico !== (a == 15 && i == 15) || erro !== 1'b0 ||
          direcao !== (i == 16)) begin
        bad++; $display("FAIL peak sample=%0d: got %h want %h", a, obsv(), expv());
      end
      total++;
    end
  endtask

  task automatic test_valley();
    for (int i = 13; i >= -1; i--) begin
      int a = (i < 0) ? 1 : i;
      send(1, a);
      if (obsv() !== expv() || vale !== (i == 0) || ciclos_completos !== ((i <= 0) ? 8'd1 : 8'd0)) begin
        bad++; $display("FAIL valley sample=%0d: got %h want %h", a, obsv(), expv());
      end
      total++;
    end
  endtask

  task automatic test_error_relock();
    int seq [7] = '{2, 3, 4, 5, 7, 8, 9};
    for (int i = 0; i < 7; i++) begin
      send(1, seq[i]);
      if (obsv() !== expv() || erro !== (i == 4) || travado !== (i != 4 && i != 5)) begin
        bad++; $display("FAIL err_relock sample=%0d: got %h want %h", seq[i], obsv(), expv());
      end
      total++;
    end
  endtask

  task automatic test_gaps();
    for (int a = 10; a <= 16; a++) begin
      send(0, $urandom_range(0, 15));
      if (obsv() !== expv() || pico !== 1'b0 || erro !== 1'b0) begin
        bad++; $display("FAIL gap_hold before=%0d: got %h want %h", a, obsv(), expv());
      end
      total++;
      send(1, (a == 16) ? 0 : a);
      if (obsv() !== expv() || erro !== (a == 16)) begin
        bad++; $display("FAIL gap_sample=%0d: got %h want %h", a % 16, obsv(), expv());
      end
      total++;
    end
`ifdef MONITOR_TRIANG_STICKY_ERR_EN
    send(0, 0);
    if (erro_sticky !== 1'b1 || erro !== 1'b0) begin
      bad++; $display("FAIL sticky_hold: got %b want 1", erro_sticky);
    end
    total++;
`endif
  endtask

  task automatic test_saturation();
    int v = 0;
    int step = 1;
    for (int n = 0; n < 270 * 30; n++) begin
      if (v == MAXV) step = -1;
      else if (v == 0) step = 1;
      v += step;
      send(1, v);
      if (obsv() !== expv()) begin
        bad++; $display("FAIL saturate n=%0d sample=%0d: got %h want %h", n, v, obsv(), expv());
      end
      total++;
    end
    if (ciclos_completos !== 8'd255) begin
      bad++; $display("FAIL saturate_final: got %0d want 255", ciclos_completos);
    end
    total++;
  endtask

  task automatic test_random();
    int v = m_prev;
    int step = m_dir ? -1 : 1;
    for (int n = 0; n < 3000; n++) begin
      bit valid = ($urandom_range(0, 3) != 0);
      int a;
      if (valid) begin
        if ($urandom_range(0, 11) == 0) begin
          a = $urandom_range(0, 15);
        end else begin
          if (v == MAXV) step = -1;
          else if (v == 0) step = 1;
          a = v + step;
        end
        v = a;
      end else begin
        a = $urandom_range(0, 15);
      end
      send(valid, a);
      if (obsv() !== expv()) begin
        bad++; $display("FAIL random n=%0d v=%0d a=%0d: got %h want %h", n, valid, a, obsv(), expv());
      end
      total++;
    end
  endtask

  initial begin
    test_reset();
    test_lock();
    test_peak();
    test_valley();
    test_error_relock();
    test_gaps();
    test_saturation();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
